// File: rtl/usb3_scramble_skp_if.sv
// usb3_scramble_skp_if: link-layer input stream and PIPE TX output bundle for usb3_scramble_skp.
// master = link-layer/PIPE side, slave = the scrambler block.
interface usb3_scramble_skp_if;
  logic        enable;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_valid;
  logic        in_ready;
  logic        in_scr_bypass;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_active;
  logic        skp_inserted;
  logic [1:0]  skp_owed;

  modport master (
    output enable, in_data, in_datak, in_valid, in_scr_bypass,
    input  in_ready, out_data, out_datak, out_active, skp_inserted, skp_owed
  );

  modport slave (
    input  enable, in_data, in_datak, in_valid, in_scr_bypass,
    output in_ready, out_data, out_datak, out_active, skp_inserted, skp_owed
  );
endinterface

// File: rtl/usb3_scramble_skp.sv
// usb3_scramble_skp: USB 3.0 TX scrambler, 4 symbols per cycle, with SKP ordered-set insertion.
// Lane 3 ([31:24]) is first on the wire; the LFSR is stepped through lanes 3..0 each cycle.
// Optional macro USB3_TX_SKP_INSERT_EN adds the SKP credit counter, insertion and backpressure;
// without it in_ready only follows reset and skp_inserted/skp_owed read 0.
module usb3_scramble_skp #(
  parameter int unsigned SKP_INTERVAL = 88,
  parameter int unsigned SKP_OWED_MAX = 2
) (
  input logic               local_clk,
  input logic               reset,
  usb3_scramble_skp_if.slave link
);

  localparam logic [7:0]  SymCom   = 8'hBC;
  localparam logic [7:0]  SymSkp   = 8'h3C;
  localparam logic [15:0] LfsrSeed = 16'hFFFF;
  // x^16 + x^5 + x^4 + x^3 + 1, Galois form shifting towards bit 15
  localparam logic [15:0] LfsrTaps = 16'h0039;
  localparam logic [31:0] SkpWord  = 32'h3C3C3C3C;

  if (SKP_OWED_MAX < 2 || SKP_OWED_MAX > 3) begin : g_bad_owed_max
    $error("usb3_scramble_skp: SKP_OWED_MAX must be 2 or 3");
  end
  if (SKP_INTERVAL < 2) begin : g_bad_interval
    $error("usb3_scramble_skp: SKP_INTERVAL must be at least 2");
  end

  // Eight serial Galois steps = one symbol's worth of LFSR advance.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ (r[15] ? LfsrTaps : 16'h0000);
    end
    return r;
  endfunction

  // Bit i of the scrambler byte is the LFSR output on step i, i.e. s[15-i].
  function automatic logic [7:0] scr_byte(input logic [15:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[15-i];
    end
    return b;
  endfunction

  logic        accept;
  logic        skp_go;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [31:0] scr_data;
  logic [7:0]  lane_sym;
  logic        lane_k;
  logic [31:0] out_data_q;
  logic [3:0]  out_datak_q;
  logic        out_active_q;
  logic        skp_inserted_q;

  assign accept = link.in_valid & link.in_ready;

`ifdef USB3_TX_SKP_INSERT_EN
  localparam int unsigned     CntW    = $clog2(SKP_INTERVAL);
  localparam logic [CntW-1:0] CntLast = CntW'(SKP_INTERVAL - 1);
  localparam logic [1:0]      OwedMax = 2'(SKP_OWED_MAX);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [1:0]      owed_q;
  logic [1:0]      owed_d;
  logic            owed_full;
  logic            credit_wrap;

  assign owed_full     = (owed_q == OwedMax);
  assign link.in_ready = ~reset & ~owed_full;
  // Idle cycles are used first; a full credit count stalls the input for one SKP word.
  assign skp_go        = (owed_q != 2'd0) & (~link.in_valid | owed_full);
  assign link.skp_owed = owed_q;

  // Credit counter: one SKP credit per SKP_INTERVAL non-SKP output words, owed count saturates.
  always_comb begin
    credit_wrap = accept && (cnt_q == CntLast);
    cnt_d       = cnt_q;
    if (accept) begin
      cnt_d = credit_wrap ? '0 : cnt_q + 1'b1;
    end
    owed_d = owed_q;
    if (credit_wrap && !skp_go && !owed_full) begin
      owed_d = owed_q + 2'd1;
    end else if (skp_go && !credit_wrap) begin
      owed_d = owed_q - 2'd1;
    end
  end

  // Credit state registers.
  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      owed_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      owed_q <= owed_d;
    end
  end
`else
  assign link.in_ready = ~reset;
  assign skp_go        = 1'b0;
  assign link.skp_owed = 2'd0;
`endif

  // Scramble lanes 3..0 in wire order; COM reseeds for the next lane, SKP freezes the LFSR.
  always_comb begin
    lfsr_d   = lfsr_q;
    scr_data = '0;
    lane_sym = '0;
    lane_k   = 1'b0;
    for (int l = 3; l >= 0; l--) begin
      lane_sym = link.in_data[8*l +: 8];
      lane_k   = link.in_datak[l];
      if (lane_k && lane_sym == SymCom) begin
        scr_data[8*l +: 8] = lane_sym;
        lfsr_d             = LfsrSeed;
      end else if (lane_k && lane_sym == SymSkp) begin
        scr_data[8*l +: 8] = lane_sym;
      end else begin
        if (!lane_k && link.enable && !link.in_scr_bypass) begin
          scr_data[8*l +: 8] = lane_sym ^ scr_byte(lfsr_d);
        end else begin
          scr_data[8*l +: 8] = lane_sym;
        end
        lfsr_d = lfsr_adv8(lfsr_d);
      end
    end
  end

  // Output word register: SKP word, scrambled input word, or an all-zero idle cycle.
  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      out_data_q     <= '0;
      out_datak_q    <= '0;
      out_active_q   <= 1'b0;
      skp_inserted_q <= 1'b0;
      lfsr_q         <= LfsrSeed;
    end else if (skp_go) begin
      out_data_q     <= SkpWord;
      out_datak_q    <= 4'b1111;
      out_active_q   <= 1'b1;
      skp_inserted_q <= 1'b1;
    end else if (accept) begin
      out_data_q     <= scr_data;
      out_datak_q    <= link.in_datak;
      out_active_q   <= 1'b1;
      skp_inserted_q <= 1'b0;
      lfsr_q         <= lfsr_d;
    end else begin
      out_data_q     <= '0;
      out_datak_q    <= '0;
      out_active_q   <= 1'b0;
      skp_inserted_q <= 1'b0;
    end
  end

  assign link.out_data     = out_data_q;
  assign link.out_datak    = out_datak_q;
  assign link.out_active   = out_active_q;
  assign link.skp_inserted = skp_inserted_q;

endmodule

// File: tb/tb_usb3_scramble_skp.sv
// tb_usb3_scramble_skp: directed vectors for usb3_scramble_skp.
// Expected scrambled words come from the USB 3.0 scrambled-zero sequence after COM:
// FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 ...
module tb_usb3_scramble_skp;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic        en;
    logic        byp;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        ea;
  } vec_t;

  localparam int NumVec = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] rx_lfsr;
  vec_t vecs [NumVec];

  always #4 clk = ~clk;

  usb3_scramble_skp_if bus ();

  usb3_scramble_skp #(
    .SKP_INTERVAL(88),
    .SKP_OWED_MAX(2)
  ) dut (
    .local_clk(clk),
    .reset    (rst),
    .link     (bus)
  );

`ifdef USB3_TX_SKP_INSERT_EN
  usb3_scramble_skp_if bus8 ();

  usb3_scramble_skp #(
    .SKP_INTERVAL(8),
    .SKP_OWED_MAX(2)
  ) dut8 (
    .local_clk(clk),
    .reset    (rst),
    .link     (bus8)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v,
                       input logic en, input logic byp);
    bus.in_data       = d;
    bus.in_datak      = k;
    bus.in_valid      = v;
    bus.enable        = en;
    bus.in_scr_bypass = byp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  // Receiver-side descrambler model, bit-serial.
  task automatic rx_descramble(input logic [31:0] d, input logic [3:0] k, output logic [31:0] q);
    logic [7:0] sym;
    logic       fb;
    q = '0;
    for (int l = 3; l >= 0; l--) begin
      sym = d[8*l +: 8];
      if (k[l] && sym == 8'hBC) begin
        rx_lfsr = 16'hFFFF;
      end else if (!(k[l] && sym == 8'h3C)) begin
        for (int b = 0; b < 8; b++) begin
          if (!k[l]) sym[b] = sym[b] ^ rx_lfsr[15];
          fb      = rx_lfsr[15];
          rx_lfsr = rx_lfsr << 1;
          if (fb) rx_lfsr = rx_lfsr ^ 16'h0039;
        end
      end
      q[8*l +: 8] = sym;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rxq;
    vecs[0]  = '{32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 1'b1};
    vecs[1]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'hFF17C014, 4'h0, 1'b1};
    vecs[2]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'hB2E70282, 4'h0, 1'b1};
    vecs[3]  = '{32'hDEADBEEF, 4'h5, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0};
    vecs[4]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'h726E28A6, 4'h0, 1'b1};
    vecs[5]  = '{32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 1'b1};
    vecs[6]  = '{32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1};
    vecs[7]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'hB2E70282, 4'h0, 1'b1};
    vecs[8]  = '{32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 1'b1};
    vecs[9]  = '{32'h4A4A4A4A, 4'h0, 1'b1, 1'b1, 1'b1, 32'h4A4A4A4A, 4'h0, 1'b1};
    vecs[10] = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'hB2E70282, 4'h0, 1'b1};
    vecs[11] = '{32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 1'b1};
    vecs[12] = '{32'h3C003C00, 4'hA, 1'b1, 1'b1, 1'b0, 32'h3CFF3C17, 4'hA, 1'b1};
    vecs[13] = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'hC014B2E7, 4'h0, 1'b1};
    vecs[14] = '{32'h0000BC00, 4'h2, 1'b1, 1'b1, 1'b0, 32'h0282BCFF, 4'h2, 1'b1};
    vecs[15] = '{32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 32'h17C014B2, 4'h0, 1'b1};
    vecs[16] = '{32'hF7000000, 4'h8, 1'b1, 1'b1, 1'b0, 32'hF7028272, 4'h8, 1'b1};

    drive(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
`ifdef USB3_TX_SKP_INSERT_EN
    bus8.in_data       = '0;
    bus8.in_datak      = '0;
    bus8.in_valid      = 1'b0;
    bus8.enable        = 1'b1;
    bus8.in_scr_bypass = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("reset_ready", {63'd0, bus.in_ready}, 64'd0);
    check("reset_out", {bus.out_data, bus.out_datak, bus.out_active, bus.skp_inserted,
                        bus.skp_owed}, 64'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].d, vecs[i].k, vecs[i].v, vecs[i].en, vecs[i].byp);
      #1;
      check($sformatf("vec%0d_ready", i), {63'd0, bus.in_ready}, 64'd1);
      tick();
      check($sformatf("vec%0d_out", i), {bus.out_data, bus.out_datak, bus.out_active},
            {vecs[i].ed, vecs[i].ek, vecs[i].ea});
      check($sformatf("vec%0d_skp", i), {bus.skp_inserted, bus.skp_owed}, 64'd0);
    end

    // Reset mid-stream for 3 cycles
    drive(32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst%0d_ready", c), {63'd0, bus.in_ready}, 64'd0);
      tick();
      check($sformatf("rst%0d_out", c), {bus.out_data, bus.out_datak, bus.out_active,
                                          bus.skp_inserted, bus.skp_owed}, 64'd0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_seed", {32'd0, bus.out_data}, {32'd0, 32'hFF17C014});
    drive(32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    check("post_rst_com", {32'd0, bus.out_data}, {32'd0, 32'hFF17C014});

    // Round trip through the receiver model
    drive(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    do_reset();
    rx_lfsr = 16'hFFFF;
    drive(32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 1'b0);
    tick();
    rx_descramble(bus.out_data, bus.out_datak, rxq);
    check("rt_com", {rxq, bus.out_datak}, {32'hBCBCBCBC, 4'hF});
    drive(32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 20; w++) begin
      tick();
      if (w == 0) check("rt_first_nonzero", {63'd0, bus.out_data != 32'h0}, 64'd1);
      rx_descramble(bus.out_data, bus.out_datak, rxq);
      check($sformatf("rt_word%0d", w), {rxq, bus.out_datak, bus.out_active},
            {32'h0, 4'h0, 1'b1});
    end
    drive(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

`ifdef USB3_TX_SKP_INSERT_EN
    begin
      int sent;
      int exp_idx;
      int skps;
      int lows;
      logic prev_low;
      logic acc;

      // Idle insertion: 8 data words earn one credit, spent on the first idle cycle
      do_reset();
      for (int w = 0; w < 7; w++) begin
        bus8.in_data  = 32'h01010101 * w;
        bus8.in_datak = 4'h0;
        bus8.enable   = 1'b0;
        bus8.in_valid = 1'b1;
        tick();
      end
      check("idle_owed_before", {62'd0, bus8.skp_owed}, 64'd0);
      bus8.in_data  = 32'hBCBCBCBC;
      bus8.in_datak = 4'hF;
      bus8.enable   = 1'b1;
      tick();
      check("idle_owed_credit", {62'd0, bus8.skp_owed}, 64'd1);
      bus8.in_valid = 1'b0;
      tick();
      check("idle_skp_word", {bus8.out_data, bus8.out_datak, bus8.out_active, bus8.skp_inserted,
                              bus8.skp_owed}, {32'h3C3C3C3C, 4'hF, 1'b1, 1'b1, 2'd0});
      bus8.in_data  = 32'h0;
      bus8.in_datak = 4'h0;
      bus8.in_valid = 1'b1;
      tick();
      check("idle_after_skp", {bus8.out_data, bus8.skp_inserted}, {32'hFF17C014, 1'b0});
      bus8.in_valid = 1'b0;

      // Forced insertion: 40 words with in_valid held, passthrough for easy ordering checks
      do_reset();
      sent     = 0;
      exp_idx  = 0;
      skps     = 0;
      lows     = 0;
      prev_low = 1'b0;
      bus8.enable = 1'b0;
      for (int c = 0; c < 120; c++) begin
        bus8.in_valid = (sent < 40);
        bus8.in_data  = sent;
        bus8.in_datak = 4'h0;
        #1;
        acc = bus8.in_valid & bus8.in_ready;
        if (bus8.in_valid && !bus8.in_ready) begin
          lows++;
          check("forced_low_single", {63'd0, prev_low}, 64'd0);
        end
        prev_low = bus8.in_valid & ~bus8.in_ready;
        tick();
        if (acc) sent++;
        if (bus8.out_active) begin
          if (bus8.skp_inserted) begin
            skps++;
            check("forced_skp_word", {32'd0, bus8.out_data}, {32'd0, 32'h3C3C3C3C});
          end else begin
            check($sformatf("forced_word%0d", exp_idx), {32'd0, bus8.out_data}, exp_idx);
            exp_idx++;
          end
        end
        if (sent == 40 && bus8.skp_owed == 2'd0 && !bus8.out_active) break;
      end
      check("forced_sent", sent, 40);
      check("forced_received", exp_idx, 40);
      check("forced_skp_count", skps, 5);
      check("forced_backpressure_cycles", lows, 3);
      bus8.in_valid = 1'b0;
    end
`else
    // Without SKP insertion the block never backpressures or inserts
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("noskp_idle%0d", c), {bus.in_ready, bus.skp_inserted, bus.skp_owed,
                                             bus.out_active}, {1'b1, 1'b0, 2'd0, 1'b0});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
